// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX stage: widths, ALU opcodes, control word.
package id_ex_stage_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_AW  = 3;
  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'h2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 4'h4;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'h5;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'h6;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'h7;

  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic aluSrc;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  // An invalid ID slot must never carry live control into EX.
  function automatic ctrl_t gateCtrl(input logic valid, input ctrl_t c);
    return valid ? c : BUBBLE_CTRL;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose rd is read by the instruction in ID.
import id_ex_stage_pkg::*;

module load_use_detect (
  input  logic              idValid,
  input  logic [REG_AW-1:0] idRa,
  input  logic [REG_AW-1:0] idRb,
  input  logic              idUseRa,
  input  logic              idUseRb,
  input  logic              exValid,
  input  logic              exMemRead,
  input  logic [REG_AW-1:0] exRd,
  output logic              luh
);

  logic matchRa;
  logic matchRb;

  // r0 is an ordinary register in this machine, so no zero-address exclusion.
  assign matchRa = idUseRa && (idRa == exRd);
  assign matchRb = idUseRb && (idRb == exRd);
  assign luh     = exValid && exMemRead && idValid && (matchRa || matchRb);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and EX-busy hold.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
import id_ex_stage_pkg::*;

module id_ex_stage (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_ra,
  input  logic [REG_AW-1:0]  id_rb,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_use_ra,
  input  logic               id_use_rb,
  input  logic [DATA_W-1:0]  id_data_a,
  input  logic [DATA_W-1:0]  id_data_b,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_alusrc,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic               flush,
  input  logic               ex_busy,
  output logic               stall,
  output logic               ex_valid,
  output logic [REG_AW-1:0]  ex_ra,
  output logic [REG_AW-1:0]  ex_rb,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [DATA_W-1:0]  ex_data_a,
  output logic [DATA_W-1:0]  ex_data_b,
  output logic [DATA_W-1:0]  ex_imm,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic [ALUOP_W-1:0] ex_aluop
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]        bubble_cnt
`endif
);

  logic               validQ;
  logic [REG_AW-1:0]  raQ;
  logic [REG_AW-1:0]  rbQ;
  logic [REG_AW-1:0]  rdQ;
  logic [DATA_W-1:0]  dataAQ;
  logic [DATA_W-1:0]  dataBQ;
  logic [DATA_W-1:0]  immQ;
  ctrl_t              ctrlQ;
  logic [ALUOP_W-1:0] aluopQ;

  ctrl_t idCtrl;
  logic  luh;
  logic  loadBubble;

  assign idCtrl = '{regWrite: id_regwrite, memRead: id_memread,
                    memWrite: id_memwrite, aluSrc: id_alusrc};

  load_use_detect uLud (
    .idValid   (id_valid),
    .idRa      (id_ra),
    .idRb      (id_rb),
    .idUseRa   (id_use_ra),
    .idUseRb   (id_use_rb),
    .exValid   (validQ),
    .exMemRead (ctrlQ.memRead),
    .exRd      (rdQ),
    .luh       (luh)
  );

  // Flush kills the ID instruction, so there is nothing left to freeze.
  assign stall      = (luh || ex_busy) && !flush;
  assign loadBubble = flush || (!ex_busy && luh);

  always_ff @(posedge clk) begin
    if (rst || loadBubble) begin
      validQ <= 1'b0;
      raQ    <= '0;
      rbQ    <= '0;
      rdQ    <= '0;
      dataAQ <= '0;
      dataBQ <= '0;
      immQ   <= '0;
      ctrlQ  <= BUBBLE_CTRL;
      aluopQ <= '0;
    end else if (!ex_busy) begin
      validQ <= id_valid;
      raQ    <= id_ra;
      rbQ    <= id_rb;
      rdQ    <= id_rd;
      dataAQ <= id_data_a;
      dataBQ <= id_data_b;
      immQ   <= id_imm;
      ctrlQ  <= gateCtrl(id_valid, idCtrl);
      aluopQ <= id_aluop;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubbleCntQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubbleCntQ <= '0;
    end else if (loadBubble && (bubbleCntQ != 16'hFFFF)) begin
      bubbleCntQ <= bubbleCntQ + 16'd1;
    end
  end

  assign bubble_cnt = bubbleCntQ;
`endif

  assign ex_valid    = validQ;
  assign ex_ra       = raQ;
  assign ex_rb       = rbQ;
  assign ex_rd       = rdQ;
  assign ex_data_a   = dataAQ;
  assign ex_data_b   = dataBQ;
  assign ex_imm      = immQ;
  assign ex_regwrite = ctrlQ.regWrite;
  assign ex_memread  = ctrlQ.memRead;
  assign ex_memwrite = ctrlQ.memWrite;
  assign ex_alusrc   = ctrlQ.aluSrc;
  assign ex_aluop    = aluopQ;

endmodule
